// File: rtl/afu_pkg.sv
// Shared definitions for the AFU tile transposer: default widths, element-count
// helpers and the job state encoding.
package afu_pkg;

  localparam int LINE_WIDTH_DEF = 512;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int elems_per_line(input int line_width, input int data_width);
    return line_width / data_width;
  endfunction

  // A single-element tile still needs a 1-bit row index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// One N x N tile buffer: rows are written one line at a time and read back
// either as rows (bypass) or as columns (transpose).
module transpose_bank
  import afu_pkg::*;
#(
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int N  = elems_per_line(LINE_WIDTH, DATA_WIDTH),
  localparam int IW = idx_width(N)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_row,
  input  logic [LINE_WIDTH-1:0] wr_data,
  input  logic [IW-1:0]         rd_idx,
  input  logic                  bypass,
  output logic [LINE_WIDTH-1:0] rd_data
);

  logic [LINE_WIDTH-1:0] mem [N];

  // Row write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  // Column read gathers element rd_idx of every stored row.
  always_comb begin
    rd_data = '0;
    if (bypass) begin
      rd_data = mem[rd_idx];
    end else begin
      for (int i = 0; i < N; i++) begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rd_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/matrix_transpose_stream.sv
// Streaming square-tile transposer with ping-pong banks: one bank fills while
// the other drains, so a line per cycle can flow in both directions.
module matrix_transpose_stream
  import afu_pkg::*;
#(
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           ctx_length,
  input  logic                  bypass,
  input  logic [LINE_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LINE_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           tiles_done
);

  localparam int N  = elems_per_line(LINE_WIDTH, DATA_WIDTH);
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  state_t          state;
  state_t          next_state;
  logic [31:0]     len;
  logic            byp;
  logic [1:0]      full;
  logic [1:0]      full_next;
  logic            wr_bank;
  logic            rd_bank;
  logic [IW-1:0]   wr_row;
  logic [IW-1:0]   rd_col;
  logic [31:0]     tiles_in;
  logic            start_job;
  logic            accept;
  logic            emit;
  logic [LINE_WIDTH-1:0] bank_rd [2];

  assign start_job = start && (state != RUN);
  assign in_ready  = (state == RUN) && !full[wr_bank] && (tiles_in < len);
  assign out_valid = full[rd_bank];
  assign out_data  = bank_rd[rd_bank];
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    transpose_bank #(
      .LINE_WIDTH (LINE_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk     (clk),
      .wr_en   (accept && (wr_bank == 1'(b))),
      .wr_row  (wr_row),
      .wr_data (in_data),
      .rd_idx  (rd_col),
      .bypass  (byp),
      .rd_data (bank_rd[b])
    );
  end

  // Job state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a start arriving mid-job is ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = RUN;
        else       next_state = IDLE;
      end
      RUN: begin
        if (tiles_done == len) next_state = DONE;
        else                   next_state = RUN;
      end
      DONE: begin
        if (start) next_state = RUN;
        else       next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Fill and drain touch different banks, so both flag updates can land together.
  always_comb begin
    full_next = full;
    if (accept && (wr_row == LAST_IDX)) begin
      full_next[wr_bank] = 1'b1;
    end else begin
      full_next[wr_bank] = full[wr_bank];
    end
    if (emit && (rd_col == LAST_IDX)) begin
      full_next[rd_bank] = 1'b0;
    end else begin
      full_next[rd_bank] = full_next[rd_bank];
    end
  end

  // Ping-pong pointers, full flags and tile counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len        <= 32'd0;
      byp        <= 1'b0;
      full       <= 2'b00;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_row     <= '0;
      rd_col     <= '0;
      tiles_in   <= 32'd0;
      tiles_done <= 32'd0;
    end else if (start_job) begin
      len        <= ctx_length;
      byp        <= bypass;
      full       <= 2'b00;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_row     <= '0;
      rd_col     <= '0;
      tiles_in   <= 32'd0;
      tiles_done <= 32'd0;
    end else begin
      full <= full_next;
      if (accept) begin
        if (wr_row == LAST_IDX) begin
          wr_row   <= '0;
          wr_bank  <= ~wr_bank;
          tiles_in <= tiles_in + 32'd1;
        end else begin
          wr_row   <= wr_row + ONE_IDX;
        end
      end
      if (emit) begin
        if (rd_col == LAST_IDX) begin
          rd_col     <= '0;
          rd_bank    <= ~rd_bank;
          tiles_done <= tiles_done + 32'd1;
        end else begin
          rd_col     <= rd_col + ONE_IDX;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Randomized scoreboard bench for matrix_transpose_stream with 64-bit lines of
// four 16-bit elements.
module tb_matrix_transpose_stream;

  localparam int LW    = 64;
  localparam int DW    = 16;
  localparam int NE    = 4;
  localparam int LIMIT = 2000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   ctx_length = 32'd0;
  logic          bypass = 1'b0;
  logic [LW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [31:0]   tiles_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_emit_cyc = -1;
  int last_emit_cyc = -1;
  int emits = 0;
  int first_acc_cyc = -1;
  int last_acc_cyc = -1;
  int acc4_cyc = -1;
  bit saw_drop = 1'b0;
  bit cur_byp = 1'b0;
  bit prev_stall = 1'b0;
  logic [LW-1:0] prev_data = '0;
  logic [LW-1:0] exp_q [$];
  logic [LW-1:0] rows_buf [$];

  matrix_transpose_stream #(.LINE_WIDTH(LW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ctx_length (ctx_length),
    .bypass     (bypass),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .tiles_done (tiles_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: element grid of the tile; transpose swaps the indices.
  task automatic push_tile();
    logic [DW-1:0] elem [NE][NE];
    logic [LW-1:0] row;
    logic [LW-1:0] line;
    for (int i = 0; i < NE; i++) begin
      row = rows_buf[i];
      for (int j = 0; j < NE; j++) elem[i][j] = row[j*DW +: DW];
    end
    for (int j = 0; j < NE; j++) begin
      line = '0;
      for (int i = 0; i < NE; i++) line[i*DW +: DW] = cur_byp ? elem[j][i] : elem[i][j];
      exp_q.push_back(line);
    end
    rows_buf.delete();
  endtask

  function automatic logic [LW-1:0] make_line(input bit fixed, input int idx);
    logic [LW-1:0] l;
    int r;
    l = '0;
    if (fixed) begin
      r = idx % NE;
      for (int j = 0; j < NE; j++) l[j*DW +: DW] = 16'(r * NE + j);
    end else begin
      l = {$urandom, $urandom};
    end
    return l;
  endfunction

  // Output monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    logic [LW-1:0] exp;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", out_data);
        end else begin
          exp = exp_q.pop_front();
          check("out_data", out_data, exp);
        end
        if (first_emit_cyc < 0) first_emit_cyc = cyc;
        last_emit_cyc = cyc;
        emits++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // rmode: 0 ready always, 1 toggling, 2 random. vmode: 0 valid held, 1 random gaps.
  task automatic run_job(input int len, input bit byp, input int n_offer,
                         input int rmode, input int vmode, input bit fixed);
    int sent;
    int start_cyc;
    int done_cyc;
    int exp_acc;
    bit ready_seen;
    bit acc;
    @(posedge clk); #1;
    ctx_length = 32'(len);
    bypass = byp;
    start = 1'b1;
    cur_byp = byp;
    rows_buf.delete();
    first_emit_cyc = -1; last_emit_cyc = -1; emits = 0;
    first_acc_cyc = -1; last_acc_cyc = -1; acc4_cyc = -1; saw_drop = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    sent = 0; done_cyc = -1; ready_seen = 1'b0;
    in_data = make_line(fixed, 0);
    in_valid = (n_offer > 0) && ((vmode == 0) || ($urandom_range(0, 1) == 1));
    out_ready = 1'b1;
    for (int guard = 0; guard < LIMIT && done_cyc < 0; guard++) begin
      @(negedge clk);
      if (done) done_cyc = cyc;
      if (in_ready) ready_seen = 1'b1;
      if (in_valid && !in_ready && busy && sent < len * NE) saw_drop = 1'b1;
      acc = in_valid && in_ready;
      if (acc) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        sent++;
        if (sent == NE) acc4_cyc = cyc;
        rows_buf.push_back(in_data);
        if (rows_buf.size() == NE) push_tile();
      end
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_data = make_line(fixed, sent);
        in_valid = (sent < n_offer) && ((vmode == 0) || ($urandom_range(0, 1) == 1));
      end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    exp_acc = (n_offer < len * NE) ? n_offer : len * NE;
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
    check("accepted", 64'(sent), 64'(exp_acc));
    check("emitted", 64'(emits), 64'(len * NE));
    check("tiles_done", 64'(tiles_done), 64'(len));
    check("busy_after", 64'(busy), 64'd0);
    check("in_ready_done", 64'(in_ready), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    if (len == 0) begin
      check("done_latency_len0", 64'(done_cyc - start_cyc), 64'd1);
      check("in_ready_len0", 64'(ready_seen), 64'd0);
    end else begin
      // Last emit handshake lands on the next edge; done follows one edge later.
      check("done_latency", 64'(done_cyc - last_emit_cyc), 64'd2);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tiles_done", 64'(tiles_done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_job(1, 1'b0, 4, 0, 0, 1'b1);

    run_job(3, 1'b0, 12, 0, 0, 1'b0);
    check("acc_consecutive", 64'(last_acc_cyc - first_acc_cyc), 64'd11);
    check("first_latency", 64'(first_emit_cyc - acc4_cyc), 64'd1);
    check("emit_back_to_back", 64'(last_emit_cyc - first_emit_cyc), 64'd11);

    run_job(3, 1'b0, 12, 1, 0, 1'b0);
    check("in_ready_drop", 64'(saw_drop), 64'd1);

    run_job(2, 1'b1, 8, 0, 0, 1'b0);

    run_job(0, 1'b0, 4, 0, 0, 1'b0);
    run_job(1, 1'b0, 5, 0, 0, 1'b0);

    // Abort a job mid-tile with an asynchronous reset.
    @(posedge clk); #1;
    ctx_length = 32'd2; bypass = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = make_line(1'b0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("pre_reset_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_data = make_line(1'b0, 0);
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_in_ready", 64'(in_ready), 64'd0);
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_done", 64'(done), 64'd0);
    check("async_tiles_done", 64'(tiles_done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_queue_empty", 64'(exp_q.size()), 64'd0);
    run_job(1, 1'b0, 4, 0, 0, 1'b0);

    run_job(5, 1'($urandom_range(0, 1)), 20, 2, 1, 1'b0);
    run_job(4, 1'b0, 16, 2, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
